// File: rtl/instr_encoder_if.sv
// Request channel between an instruction source and the instruction encoder.
//
// Signals:
//   in_valid  - an instruction request is present
//   in_ready  - encoder can accept a request this cycle
//   op_sel    - operation select (0 add .. 9 j, 10-15 illegal)
//   rs/rt/rd  - register fields
//   imm       - immediate or branch offset
//   target    - jump target field
//
// Modports:
//   master - the request source
//   slave  - the encoder
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;

    modport master (
        output in_valid, op_sel, rs, rt, rd, imm, target,
        input  in_ready
    );

    modport slave (
        input  in_valid, op_sel, rs, rt, rd, imm, target,
        output in_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts instruction requests one per cycle, encodes
// them into 32-bit MIPS words and writes them sequentially into an
// instruction memory starting at word 0.
//
// Ports:
//   clk        - single clock, rising-edge
//   reset      - synchronous active-high reset
//   req        - request channel (slave side of instr_encoder_if)
//   finish     - single-cycle pulse that ends loading
//   imem_we    - instruction-memory write strobe
//   imem_addr  - instruction-memory word address
//   imem_wdata - encoded instruction word
//   count      - number of words written
//   illegal    - sticky: an illegal op_sel was accepted
//   full       - DEPTH words have been written
//   done       - loading has been ended by finish
module instr_encoder #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    instr_encoder_if.slave      req,
    input  logic                finish,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [31:0]         imem_wdata,
    output logic [ADDR_W:0]     count,
    output logic                illegal,
    output logic                full,
    output logic                done
);

    typedef enum logic [1:0] {
        LOAD,
        FULL,
        DONE
    } state_t;

    // count value just before the write that fills the memory
    localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(DEPTH - 1);

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   wptr;
    logic                accept;
    logic                legal;
    logic                write_en;
    logic                last_write;
    logic [31:0]         enc;

    // Requests are only taken while loading; reset masks ready in the same
    // cycle since the reset is synchronous and the state is not yet LOAD.
    assign req.in_ready = (state == LOAD) && !reset;
    assign accept       = req.in_valid && req.in_ready;
    assign write_en     = accept && legal;
    assign last_write   = (count == LAST_COUNT);
    assign done         = (state == DONE);

    // Field packing per instruction format
    always_comb begin
        enc   = 32'd0;
        legal = 1'b1;
        case (req.op_sel)
            4'd0:    enc = {6'd0, req.rs, req.rt, req.rd, 5'd0, 6'd32};
            4'd1:    enc = {6'd0, req.rs, req.rt, req.rd, 5'd0, 6'd34};
            4'd2:    enc = {6'd0, req.rs, req.rt, req.rd, 5'd0, 6'd36};
            4'd3:    enc = {6'd0, req.rs, req.rt, req.rd, 5'd0, 6'd37};
            4'd4:    enc = {6'd0, req.rs, req.rt, req.rd, 5'd0, 6'd42};
            4'd5:    enc = {6'd8,  req.rs, req.rt, req.imm};
            4'd6:    enc = {6'd35, req.rs, req.rt, req.imm};
            4'd7:    enc = {6'd43, req.rs, req.rt, req.imm};
            4'd8:    enc = {6'd4,  req.rs, req.rt, req.imm};
            4'd9:    enc = {6'd2,  req.target};
            default: legal = 1'b0;
        endcase
    end

    // finish wins over filling, so a finish coinciding with the last write
    // goes straight to DONE (full is still raised by the datapath below).
    always_comb begin
        next_state = state;
        case (state)
            LOAD: begin
                if (finish)
                    next_state = DONE;
                else if (write_en && last_write)
                    next_state = FULL;
            end
            FULL: begin
                if (finish)
                    next_state = DONE;
            end
            DONE: next_state = DONE;
            default: next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LOAD;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            wptr       <= '0;
            count      <= '0;
            illegal    <= 1'b0;
            full       <= 1'b0;
        end else begin
            state   <= next_state;
            imem_we <= write_en;
            if (write_en) begin
                imem_addr  <= wptr;
                imem_wdata <= enc;
                wptr       <= wptr + ADDR_W'(1);
                count      <= count + (ADDR_W+1)'(1);
                if (last_write)
                    full <= 1'b1;
            end
            if (accept && !legal)
                illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (DEPTH=4 so the fill boundary is
// reachable quickly). Expected values come from a behavioural model that
// tracks words written, sticky flags and the last write.
module tb_instr_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              reset;
    logic              finish;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              illegal;
    logic              full;
    logic              done;

    instr_encoder_if rif ();

    instr_encoder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (rif),
        .finish     (finish),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .illegal    (illegal),
        .full       (full),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          mCount   = 0;
    bit          mIllegal = 0;
    bit          mFull    = 0;
    bit          mDone    = 0;
    bit          mWe      = 0;
    int          mAddr    = 0;
    logic [31:0] mData    = 32'd0;

    function automatic logic [31:0] refEncode(input int op, input int a, input int b,
                                              input int c, input int im, input int tg);
        int functs[5] = '{32, 34, 36, 37, 42};
        int opcodes[4] = '{8, 35, 43, 4};
        longint w;
        if (op <= 4)
            w = a * (1 << 21) + b * (1 << 16) + c * (1 << 11) + functs[op];
        else if (op <= 8)
            w = longint'(opcodes[op - 5]) * (1 << 26) + a * (1 << 21) + b * (1 << 16) + im;
        else
            w = 2 * (1 << 26) + tg;
        return w[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("imem_we",    32'(imem_we),    32'(mWe));
        check("imem_addr",  32'(imem_addr),  32'(mAddr));
        check("imem_wdata", imem_wdata,      mData);
        check("count",      32'(count),      32'(mCount));
        check("illegal",    32'(illegal),    32'(mIllegal));
        check("full",       32'(full),       32'(mFull));
        check("done",       32'(done),       32'(mDone));
    endtask

    // Drive one cycle of inputs, check in_ready before the edge, advance the
    // model across the edge, then check the registered outputs.
    task automatic applyStimulus(input logic v, input logic [3:0] op,
                                 input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                                 input logic [15:0] im, input logic [25:0] tg,
                                 input logic fin, input logic rst);
        bit ready;
        bit acc;
        rif.in_valid = v;
        rif.op_sel   = op;
        rif.rs       = a;
        rif.rt       = b;
        rif.rd       = c;
        rif.imm      = im;
        rif.target   = tg;
        finish       = fin;
        reset        = rst;
        #1;
        ready = !rst && !mDone && !mFull;
        check("in_ready", 32'(rif.in_ready), 32'(ready));
        acc = v && ready;
        if (rst) begin
            mCount = 0; mIllegal = 0; mFull = 0; mDone = 0;
            mWe = 0; mAddr = 0; mData = 32'd0;
        end else begin
            mWe = 0;
            if (acc && op <= 9) begin
                mWe   = 1;
                mAddr = mCount;
                mData = refEncode(int'(op), int'(a), int'(b), int'(c), int'(im), int'(tg));
                mCount++;
                if (mCount == DEPTH) mFull = 1;
            end
            if (acc && op > 9) mIllegal = 1;
            if (fin) mDone = 1;
        end
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rif.in_valid = 0; rif.op_sel = 0; rif.rs = 0; rif.rt = 0; rif.rd = 0;
        rif.imm = 0; rif.target = 0; finish = 0; reset = 1;

        // Reset state, then ready right after release
        doReset();
        doReset();
        idle();

        // add rs=1 rt=2 rd=3
        applyStimulus(1, 0, 1, 2, 3, 0, 0, 0, 0);
        check("add_word", imem_wdata, 32'h00221820);

        // addi / beq / j back to back
        doReset();
        applyStimulus(1, 5, 0, 8, 0, 16'h0005, 0, 0, 0);
        check("addi_word", imem_wdata, 32'h20080005);
        applyStimulus(1, 8, 8, 0, 0, 16'hFFFE, 0, 0, 0);
        check("beq_word", imem_wdata, 32'h1100FFFE);
        applyStimulus(1, 9, 0, 0, 0, 0, 26'h0000010, 0, 0);
        check("j_word", imem_wdata, 32'h08000010);

        // lw, illegal op 12, sw: addresses stay contiguous
        doReset();
        applyStimulus(1, 6, 29, 4, 0, 16'd8, 0, 0, 0);
        check("lw_word", imem_wdata, 32'h8FA40008);
        applyStimulus(1, 12, 29, 4, 0, 16'd8, 0, 0, 0);
        applyStimulus(1, 7, 29, 4, 0, 16'd12, 0, 0, 0);
        check("sw_word", imem_wdata, 32'hAFA4000C);
        check("sw_addr", 32'(imem_addr), 32'd1);

        // Five consecutive requests into a four-word memory
        doReset();
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 4'(i % 5), 5'(i), 5'(i + 1), 5'(i + 2), 0, 0, 0, 0);
        idle();
        check("full_count", 32'(count), 32'(DEPTH));

        // finish while full
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();

        // finish coincident with an accepted request, then ignored traffic
        doReset();
        applyStimulus(1, 1, 3, 4, 5, 0, 0, 0, 0);
        applyStimulus(1, 2, 6, 7, 8, 0, 0, 1, 0);
        applyStimulus(1, 3, 1, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 2, 2, 2, 0, 0, 1, 0);

        // finish coincident with the filling write
        doReset();
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 5, 5'(i), 5'(i), 0, 16'(i * 3), 0, 0, 0);
        applyStimulus(1, 9, 0, 0, 0, 0, 26'h3FFFFFF, 1, 0);
        idle();

        // Reset in the cycle after an accept drops the pending write
        doReset();
        applyStimulus(1, 12, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 9, 9, 9, 0, 0, 0, 0);
        applyStimulus(1, 0, 9, 9, 9, 0, 0, 1, 1);
        applyStimulus(1, 3, 10, 11, 12, 0, 0, 0, 0);
        check("post_reset_addr", 32'(imem_addr), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0),
                          4'($urandom_range(0, 15)),
                          5'($urandom), 5'($urandom), 5'($urandom),
                          16'($urandom), 26'($urandom),
                          1'($urandom_range(0, 24) == 0),
                          1'($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, number of instruction-memory words.
REQ-002 The block SHALL have parameter ADDR_W, default 6, instruction-memory address width; DEPTH <= 2^ADDR_W.
REQ-003 The block SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  in  1  an instruction request is present.
REQ-006 The block SHALL have port in_ready  out  1  the request is accepted this cycle when in_valid & in_ready.
REQ-007 The block SHALL have port op_sel  in  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 addi, 6 lw, 7 sw, 8 beq, 9 j, 10-15 illegal.
REQ-008 The block SHALL have ports rs, rt, rd  in  5 each  register fields.
REQ-009 The block SHALL have port imm  in  16  immediate or branch offset.
REQ-010 The block SHALL have port target  in  26  jump target field.
REQ-011 The block SHALL have port finish  in  1  single-cycle pulse that ends loading.
REQ-012 The block SHALL have port imem_we  out  1  instruction-memory write strobe.
REQ-013 The block SHALL have port imem_addr  out  ADDR_W  instruction-memory word address.
REQ-014 The block SHALL have port imem_wdata  out  32  encoded MIPS instruction word.
REQ-015 The block SHALL have port count  out  ADDR_W+1  number of words written.
REQ-016 The block SHALL have port illegal  out  1  sticky flag: an illegal op_sel was accepted.
REQ-017 The block SHALL have ports full and done  out  1 each  status flags.

Function
REQ-018 Encoding SHALL be: R-type ops 0-4 -> {6'd0, rs, rt, rd, 5'd0, funct}, with funct 32/34/36/37/42 for add/sub/and/or/slt.
REQ-019 I-type encoding SHALL be {opcode, rs, rt, imm}, with opcode addi 8, lw 35, sw 43, beq 4; rd ignored.
REQ-020 Jump encoding SHALL be {6'd2, target}; rs/rt/rd/imm ignored.
REQ-021 The FSM SHALL have states LOAD, FULL and DONE; reset enters LOAD.
REQ-022 in_ready SHALL be 1 only in LOAD, giving throughput of one request per cycle.
REQ-023 Latency SHALL be one cycle: a legal op accepted in cycle N produces imem_we=1, imem_addr=wptr and imem_wdata=encoding in cycle N+1; imem_we is 0 otherwise.
REQ-024 wptr and count SHALL increment by 1 on each write, in the same edge that registers the write.
REQ-025 An accepted illegal op SHALL produce no write and no pointer change, and SHALL set illegal, which holds until reset.
REQ-026 When an accepted legal op makes count reach DEPTH, the FSM SHALL go LOAD->FULL on that edge; full=1 and in_ready=0 from the next cycle.
REQ-027 A finish pulse in LOAD or FULL SHALL cause a transition to DONE on that edge; done=1 and in_ready=0 until reset.
REQ-028 When finish and an accepted request coincide, the request SHALL be written normally, then DONE.
REQ-029 When finish and the DEPTH-th write coincide, the FSM SHALL enter DONE, with full also set.
REQ-030 finish in DONE SHALL be ignored, and in_valid SHALL be ignored outside LOAD.
REQ-031 imem_addr and imem_wdata SHALL hold their last value when imem_we=0.

Reset
REQ-032 While reset=1, the block SHALL set: imem_we=0, imem_addr=0, imem_wdata=0, count=0, wptr=0, illegal=0, full=0, done=0, state LOAD; in_ready=0 during reset.
REQ-033 Reset SHALL take priority over all inputs; a write pending from the cycle before reset SHALL be dropped (imem_we=0 in the cycle after reset asserts).
REQ-034 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-035 add rs=1 rt=2 rd=3 accepted -> next cycle imem_we=1, addr=0, wdata=0x00221820; count=1.
REQ-036 Back-to-back addi rs=0 rt=8 imm=0x0005, then beq rs=8 rt=0 imm=0xFFFE, then j target=0x0000010 -> writes 0x20080005 @0, 0x1100FFFE @1, 0x08000010 @2 on consecutive cycles.
REQ-037 lw rs=29 rt=4 imm=8 and sw rs=29 rt=4 imm=12 -> 0x8FA40008 and 0xAFA4000C; op_sel=12 in between -> no write, illegal=1, addresses stay contiguous.
REQ-038 With DEPTH=4, 5 consecutive valid requests -> 4 writes (addr 0-3), full=1, in_ready=0, fifth request not accepted, count=4.
REQ-039 finish coincident with a valid or request -> that word written, then done=1, in_ready=0; later in_valid produces no writes.
REQ-040 reset asserted in the cycle after an accept -> imem_we=0, count=0, illegal=0, done=0; first accept after release writes addr 0.
